tdm_demux8: RTL

//  Receive end of the 8:1 lane-mux link: rebuilds 8 parallel lanes from a time-division

---
 rtl/tdm_demux8.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tdm_demux8.sv
// Receive side of an 8:1 TDM lane link: collects slots 0..7 into a parallel word.
// Optional sync-error counter is enabled by defining ERR_COUNT_EN.
module tdm_demux8 #(
  parameter int LANE_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANE_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [8*LANE_W-1:0]   dout,
  output logic                  dout_valid,
  output logic [2:0]            slot,
  output logic                  locked,
  output logic                  sync_err,
  output logic [7:0]            err_cnt
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_slot;
  logic [2:0]            w_slot_next;
  logic [LANE_W-1:0]     r_shadow [7];
  logic [8*LANE_W-1:0]   r_dout;
  logic [8*LANE_W-1:0]   w_dout_next;
  logic                  r_dout_valid;
  logic                  w_dout_valid_next;
  logic                  r_sync_err;
  logic                  w_sync_err_next;
  logic                  w_wr_en;
  logic [2:0]            w_wr_slot;
  logic [8*LANE_W-1:0]   w_frame;

  // Slot 7 is never stored: it goes straight from din into the published word.
  assign w_frame[7*LANE_W +: LANE_W] = din;

  for (genvar gi = 0; gi < 7; gi++) begin : g_lane
    assign w_frame[gi*LANE_W +: LANE_W] = r_shadow[gi];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_shadow[gi] <= '0;
      end else if (w_wr_en && (w_wr_slot == 3'(gi))) begin
        r_shadow[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_slot_next       = r_slot;
    w_dout_next       = r_dout;
    w_dout_valid_next = 1'b0;
    w_sync_err_next   = 1'b0;
    w_wr_en           = 1'b0;
    w_wr_slot         = r_slot;
    if (din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (frame_sync) begin
            w_wr_en      = 1'b1;
            w_wr_slot    = 3'd0;
            w_slot_next  = 3'd1;
            w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync && (r_slot != 3'd0)) begin
            // Misplaced sync: drop the partial frame and restart at slot 0.
            w_sync_err_next = 1'b1;
            w_wr_en         = 1'b1;
            w_wr_slot       = 3'd0;
            w_slot_next     = 3'd1;
          end else if (r_slot == 3'd7) begin
            w_dout_next       = w_frame;
            w_dout_valid_next = 1'b1;
            w_slot_next       = 3'd0;
          end else begin
            w_wr_en     = 1'b1;
            w_slot_next = r_slot + 3'd1;
          end
        end
        default: w_state_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot       <= 3'd0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_slot       <= w_slot_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_sync_err   <= w_sync_err_next;
    end
  end

`ifdef ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_sync_err_next && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == ST_LOCKED);
  assign sync_err   = r_sync_err;

endmodule
